// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle RISC-V main controller: states, ALUOp,
// opcodes, datapath select values and the immediate-format decode.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        aluop_t     alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        pc_update:  1'b0,
        branch:     1'b0,
        adr_src:    ADR_PC,
        mem_write:  1'b0,
        ir_write:   1'b0,
        result_src: RES_ALUOUT,
        alu_src_a:  SRCA_PC,
        alu_src_b:  SRCB_WD,
        reg_write:  1'b0,
        alu_op:     ALUOP_ADD
    };

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/main_fsm_alu_decoder.sv
// ALU control decode: maps ALUOp plus funct3/funct7b5/op[5] to the ALU operation.
module alu_decoder
    import main_fsm_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Only R-type (op[5]=1) with funct7b5 selects subtract; addi never does.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V main controller: state register, next-state logic and
// Moore control decode; pc_write, imm_src and alu_control also see the inputs.
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_s;
    logic   op_supported_s;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: next_state_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXECUTER;
                    OP_ITYPE:     next_state_s = S_EXECUTEI;
                    OP_BEQ:       next_state_s = S_BEQ;
                    OP_JAL:       next_state_s = S_JAL;
                    default:      next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state_s = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state_s = S_MEMWB;
            S_EXECUTER: next_state_s = S_ALUWB;
            S_EXECUTEI: next_state_s = S_ALUWB;
            S_JAL:      next_state_s = S_ALUWB;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Moore control decode; everything is held idle while rst_n is low
    always_comb begin
        ctrl_s = CTRL_IDLE;
        if (!rst_n) begin
            ctrl_s = CTRL_IDLE;
        end else begin
            case (state_r)
                S_FETCH: begin
                    ctrl_s.adr_src    = ADR_PC;
                    ctrl_s.ir_write   = 1'b1;
                    ctrl_s.alu_src_a  = SRCA_PC;
                    ctrl_s.alu_src_b  = SRCB_FOUR;
                    ctrl_s.result_src = RES_ALURESULT;
                    ctrl_s.pc_update  = 1'b1;
                end
                S_DECODE: begin
                    ctrl_s.alu_src_a = SRCA_OLDPC;
                    ctrl_s.alu_src_b = SRCB_IMM;
                end
                S_MEMADR: begin
                    ctrl_s.alu_src_a = SRCA_A;
                    ctrl_s.alu_src_b = SRCB_IMM;
                end
                S_MEMREAD: begin
                    ctrl_s.result_src = RES_ALUOUT;
                    ctrl_s.adr_src    = ADR_ALUOUT;
                end
                S_MEMWRITE: begin
                    ctrl_s.result_src = RES_ALUOUT;
                    ctrl_s.adr_src    = ADR_ALUOUT;
                    ctrl_s.mem_write  = 1'b1;
                end
                S_MEMWB: begin
                    ctrl_s.result_src = RES_DATA;
                    ctrl_s.reg_write  = 1'b1;
                end
                S_EXECUTER: begin
                    ctrl_s.alu_src_a = SRCA_A;
                    ctrl_s.alu_src_b = SRCB_WD;
                    ctrl_s.alu_op    = ALUOP_FUNCT;
                end
                S_EXECUTEI: begin
                    ctrl_s.alu_src_a = SRCA_A;
                    ctrl_s.alu_src_b = SRCB_IMM;
                    ctrl_s.alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    ctrl_s.result_src = RES_ALUOUT;
                    ctrl_s.reg_write  = 1'b1;
                end
                S_BEQ: begin
                    ctrl_s.alu_src_a  = SRCA_A;
                    ctrl_s.alu_src_b  = SRCB_WD;
                    ctrl_s.alu_op     = ALUOP_SUB;
                    ctrl_s.result_src = RES_ALUOUT;
                    ctrl_s.branch     = 1'b1;
                end
                S_JAL: begin
                    ctrl_s.alu_src_a  = SRCA_OLDPC;
                    ctrl_s.alu_src_b  = SRCB_FOUR;
                    ctrl_s.result_src = RES_ALUOUT;
                    ctrl_s.pc_update  = 1'b1;
                end
                default: ctrl_s = CTRL_IDLE;
            endcase
        end
    end

    // Opcode legality check used for the DECODE-cycle illegal pulse
    always_comb begin
        op_supported_s = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: op_supported_s = 1'b1;
            default:                                          op_supported_s = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl_s.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

    assign pc_write      = ctrl_s.pc_update | (ctrl_s.branch & zero);
    assign adr_src       = ctrl_s.adr_src;
    assign mem_write     = ctrl_s.mem_write;
    assign ir_write      = ctrl_s.ir_write;
    assign result_src    = ctrl_s.result_src;
    assign alu_src_a     = ctrl_s.alu_src_a;
    assign alu_src_b     = ctrl_s.alu_src_b;
    assign reg_write     = ctrl_s.reg_write;
    assign imm_src       = rst_n ? imm_src_of(op) : IMM_I;
    assign illegal_instr = rst_n && (state_r == S_DECODE) && !op_supported_s;

endmodule

// File: tb/tb_main_fsm.sv
// Randomized bench for main_fsm: each instruction expands into the list of
// states it must walk through, and each cycle's outputs follow from that state.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int n_checks = 0;
    int n_pass   = 0;

    main_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .reg_write(reg_write), .imm_src(imm_src),
        .alu_control(alu_control), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    wire [16:0] obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                       alu_src_b, reg_write, imm_src, alu_control, illegal_instr};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_supported(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // Expected outputs for one cycle spent in the named state
    function automatic logic [16:0] exp_vec(input string st, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7,
                                            input logic z);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] alu, fa;
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
        res = 2'd0; sa = 2'd0; sb = 2'd0; alu = 3'd0;
        imm = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 :
              (o == 7'b1101111) ? 2'd3 : 2'd0;
        if (f3 == 3'd0)      fa = (o[5] && f7) ? 3'd1 : 3'd0;
        else if (f3 == 3'd2) fa = 3'd5;
        else if (f3 == 3'd6) fa = 3'd3;
        else if (f3 == 3'd7) fa = 3'd2;
        else                 fa = 3'd0;
        if (st == "FETCH") begin
            irw = 1'b1; sb = 2'd2; res = 2'd2; pcw = 1'b1;
        end else if (st == "DECODE") begin
            sa = 2'd1; sb = 2'd1; ill = !is_supported(o);
        end else if (st == "MEMADR") begin
            sa = 2'd2; sb = 2'd1;
        end else if (st == "MEMREAD") begin
            adr = 1'b1;
        end else if (st == "MEMWRITE") begin
            adr = 1'b1; mw = 1'b1;
        end else if (st == "MEMWB") begin
            res = 2'd1; rw = 1'b1;
        end else if (st == "EXECUTER") begin
            sa = 2'd2; alu = fa;
        end else if (st == "EXECUTEI") begin
            sa = 2'd2; sb = 2'd1; alu = fa;
        end else if (st == "ALUWB") begin
            rw = 1'b1;
        end else if (st == "BEQ") begin
            sa = 2'd2; alu = 3'd1; pcw = z;
        end else if (st == "JAL") begin
            sa = 2'd1; sb = 2'd2; pcw = 1'b1;
        end
        return {pcw, adr, mw, irw, res, sa, sb, rw, imm, alu, ill};
    endfunction

    // Drive reset low mid-cycle, check idle outputs before and after the edge, release
    task automatic apply_reset();
        rst_n = 1'b0;
        #1 check_val("reset_low", obs, 32'd0);
        @(posedge clk);
        #1 check_val("reset_edge", obs, 32'd0);
        rst_n = 1'b1;
    endtask

    // Run one instruction from FETCH; stop_at >= 0 abandons it after that cycle
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input int stop_at);
        string seq[$];
        logic z;
        seq = {"FETCH", "DECODE"};
        case (o)
            7'b0000011: begin seq.push_back("MEMADR"); seq.push_back("MEMREAD"); seq.push_back("MEMWB"); end
            7'b0100011: begin seq.push_back("MEMADR"); seq.push_back("MEMWRITE"); end
            7'b0110011: begin seq.push_back("EXECUTER"); seq.push_back("ALUWB"); end
            7'b0010011: begin seq.push_back("EXECUTEI"); seq.push_back("ALUWB"); end
            7'b1100011: seq.push_back("BEQ");
            7'b1101111: begin seq.push_back("JAL"); seq.push_back("ALUWB"); end
            default: ;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            op = o; funct3 = f3; funct7b5 = f7; zero = z;
            #1;
            check_val({"state_", seq[i]}, obs, exp_vec(seq[i], o, f3, f7, z));
            check_val("rw_mw_exclusive", reg_write & mem_write, 32'd0);
            if (i == 0) begin
                check_val("fetch_ir_write", ir_write, 32'd1);
                check_val("fetch_pc_write", pc_write, 32'd1);
            end else begin
                check_val("ir_write_off", ir_write, 32'd0);
            end
            if (i == stop_at) return;
        end
    endtask

    function automatic logic [6:0] rand_op(input int sel);
        logic [6:0] o;
        case (sel)
            0: o = 7'b0000011;
            1: o = 7'b0100011;
            2: o = 7'b0110011;
            3: o = 7'b0010011;
            4: o = 7'b1100011;
            5: o = 7'b1101111;
            default: begin
                o = 7'($urandom);
                while (is_supported(o)) o = 7'($urandom);
            end
        endcase
        return o;
    endfunction

    initial begin
        apply_reset();
        run_instr(7'b0000011, 3'd2, 1'b0, 2, -1);   // lw
        run_instr(7'b0100011, 3'd2, 1'b0, 2, -1);   // sw
        run_instr(7'b0110011, 3'd0, 1'b1, 2, -1);   // sub
        run_instr(7'b0010011, 3'd0, 1'b1, 2, -1);   // addi with funct7b5 set: still add
        run_instr(7'b1100011, 3'd0, 1'b0, 1, -1);   // beq taken
        run_instr(7'b1100011, 3'd0, 1'b0, 0, -1);   // beq not taken
        run_instr(7'b1101111, 3'd0, 1'b0, 2, -1);   // jal
        run_instr(7'b1111111, 3'd0, 1'b0, 2, -1);   // unsupported
        run_instr(7'b0110011, 3'd7, 1'b0, 2, 2);    // reset while in EXECUTER
        apply_reset();
        for (int n = 0; n < 200; n++) begin
            logic [6:0] o;
            int stop;
            o = rand_op(int'($urandom_range(0, 6)));
            stop = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(o, 3'($urandom), 1'($urandom), 2, stop);
            if (stop >= 0) apply_reset();
        end
        run_instr(7'b0000011, 3'd2, 1'b0, 2, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
Parameters: none.
REQ-001 The block SHALL have one clock and reset is synchronous and active-low; ports SHALL be named clk and rst_n.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 op  in  7  opcode, instr[6:0], valid while instruction register holds current instruction.
REQ-005 funct3  in  3  instr[14:12].
REQ-006 funct7b5  in  1  instr[30].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 pc_write  out  1  PC load enable = pc_update OR (branch AND zero).
REQ-009 adr_src  out  1  memory address select: 0 PC, 1 ALUOut.
REQ-010 mem_write  out  1  data-memory write enable.
REQ-011 ir_write  out  1  instruction-register (and OldPC) load enable.
REQ-012 result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-013 alu_src_a  out  2  00 PC, 01 OldPC, 10 A (register-file RD1 latch).
REQ-014 alu_src_b  out  2  00 WriteData (RD2 latch), 01 ImmExt, 10 constant 4.
REQ-015 reg_write  out  1  drives register-file WE3; write address/data taken from rd / Result.
REQ-016 imm_src  out  2  00 I, 01 S, 10 B, 11 J; combinational from op, independent of state.
REQ-017 alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 illegal_instr  out  1  one-cycle pulse in DECODE for an unsupported op.

Function
REQ-019 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL; one state per cycle.
REQ-020 Transitions: FETCH->DECODE; DECODE->MEMADR (op 0000011/0100011), EXECUTER (0110011), EXECUTEI (0010011), BEQ (1100011), JAL (1101111), otherwise FETCH; MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-021 Outputs SHALL be Moore (state-only) except pc_write, imm_src, alu_control; unlisted enables 0, unlisted selects 00.
REQ-022 FETCH: adr_src 0, ir_write 1, src_a 00, src_b 10, ALUOp add, result_src 10, pc_update 1.
REQ-023 DECODE: src_a 01, src_b 01, ALUOp add (branch/jump target into ALUOut).
REQ-024 MEMADR: src_a 10, src_b 01, ALUOp add; MEMREAD: result_src 00, adr_src 1; MEMWRITE: result_src 00, adr_src 1, mem_write 1; MEMWB: result_src 01, reg_write 1.
REQ-025 EXECUTER: src_a 10, src_b 00, ALUOp funct; EXECUTEI: src_a 10, src_b 01, ALUOp funct; ALUWB: result_src 00, reg_write 1.
REQ-026 BEQ: src_a 10, src_b 00, ALUOp sub, result_src 00, branch 1; pc_write asserts that cycle only if zero=1.
REQ-027 JAL: src_a 01, src_b 10, ALUOp add, result_src 00, pc_update 1.
REQ-028 ALU decode: ALUOp add->000; sub->001; funct: funct3 000 -> 001 if op[5] AND funct7b5 else 000; 010->101; 110->011; 111->010; any other funct3->000.
REQ-029 reg_write and mem_write SHALL never both be 1; ir_write SHALL be 1 only in FETCH.
REQ-030 Latency: lw 5 cycles, sw/R/I/jal 4, beq 3, unsupported op 2 (FETCH, DECODE).

Reset
REQ-031 rst_n=0 at a rising edge SHALL force state FETCH regardless of current state, including mid-instruction.
REQ-032 While rst_n=0, reg_write, mem_write, ir_write, pc_write SHALL be 0; all selects 00.
REQ-033 First cycle after rst_n rises SHALL be FETCH with REQ-022 outputs.

Structure
REQ-034 State encoding, ALUOp encoding, opcode constants and all select encodings SHALL live in a shared package.
REQ-035 ALU decode (REQ-028) SHALL be a sub-module alu_decoder; state register and next-state logic stay in main_fsm.

Verification
REQ-036 Reset: hold rst_n=0 in EXECUTER, release -> FETCH, ir_write=1, pc_write=1, reg_write=0.
REQ-037 lw (op 0000011): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 only cycle 5 with result_src 01.
REQ-038 sub (op 0110011, funct3 000, funct7b5 1): EXECUTER alu_control=001; ALUWB reg_write=1, result_src 00.
REQ-039 beq with zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both return to FETCH.
REQ-040 op 1111111 -> illegal_instr pulse in DECODE, next FETCH, no reg_write/mem_write.
REQ-041 sw: mem_write=1 exactly one cycle (MEMWRITE), adr_src 1, reg_write=0 throughout.
